// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the FIFO8x9 controller.
package fifo_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_DW    = 9;
  localparam int unsigned FIFO_CW    = 4;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/fifo8x9_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; after reset requester 0 wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_p1;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt = last_p1 ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last_p1 <= 1'b1;
    else if (|gnt) last_p1 <= gnt[1];
  end

endmodule

// File: rtl/fifo8x9_ctrl.sv
// Write-port arbiter and pointer/occupancy controller for the FIFO8x9 datapath.
module fifo8x9_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned DW    = FIFO_DW,
  parameter int unsigned CW    = FIFO_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          p0_valid,
  input  logic [DW-1:0] p0_data,
  output logic          p0_ready,
  input  logic          p1_valid,
  input  logic [DW-1:0] p1_data,
  output logic          p1_ready,
  input  logic          pop_req,
  output logic          pop_ack,
  output logic          rd_valid,
  output logic          fifo_wren,
  output logic          fifo_wrinc,
  output logic          fifo_wrptrclr,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_rden,
  output logic          fifo_rdinc,
  output logic          fifo_rdptrclr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err_udf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  state_t        state;
  logic [PW-1:0] wr_sh;
  logic [PW-1:0] rd_sh;
  logic [1:0]    gnt;
  logic          in_clr;
  logic          accept;
  logic          wr_go;
  logic          rd_go;
  logic          wr_wrap;
  logic          rd_wrap;

  // Gating with rst keeps every strobe low while reset is held, so the
  // INIT clear pulse appears only in the first cycle after release.
  always_comb begin
    in_clr  = !rst && (state != ST_RUN);
    accept  = !rst && (state == ST_RUN) && !flush;
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    wr_go   = |gnt;
    rd_go   = accept && pop_req && !empty;
    wr_wrap = (wr_sh == PTR_LAST);
    rd_wrap = (rd_sh == PTR_LAST);
  end

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({p1_valid, p0_valid}),
    .en  (accept && !full),
    .gnt (gnt)
  );

  always_comb begin
    p0_ready      = gnt[0];
    p1_ready      = gnt[1];
    fifo_wren     = wr_go;
    fifo_din      = gnt[1] ? p1_data : p0_data;
    fifo_wrinc    = wr_go && !wr_wrap;
    fifo_wrptrclr = in_clr || (wr_go && wr_wrap);
    pop_ack       = rd_go;
    fifo_rden     = rd_go;
    fifo_rdinc    = rd_go && !rd_wrap;
    fifo_rdptrclr = in_clr || (rd_go && rd_wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      count    <= '0;
      wr_sh    <= '0;
      rd_sh    <= '0;
      rd_valid <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (accept && pop_req && empty) err_udf <= 1'b1;
      unique case (state)
        ST_INIT: begin
          state <= ST_RUN;
          count <= '0;
          wr_sh <= '0;
          rd_sh <= '0;
        end
        ST_RUN: begin
          if (flush) begin
            // Count and shadows clear on entry so FLUSH already reports empty.
            state <= ST_FLUSH;
            count <= '0;
            wr_sh <= '0;
            rd_sh <= '0;
          end else begin
            if (wr_go && !rd_go)      count <= count + CW'(1);
            else if (!wr_go && rd_go) count <= count - CW'(1);
            if (wr_go) wr_sh <= wr_wrap ? '0 : wr_sh + PW'(1);
            if (rd_go) rd_sh <= rd_wrap ? '0 : rd_sh + PW'(1);
          end
        end
        ST_FLUSH: begin
          state <= ST_RUN;
          count <= '0;
          wr_sh <= '0;
          rd_sh <= '0;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
